// File: rtl/lvds_rx_pkg.sv
// Shared encodings and helpers for the multi-channel LVDS receiver.
package lvds_rx_pkg;

    // Per-lane framing FSM encodings, visible on o_debug_state
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_I_PHASE = 2'b01;
    localparam logic [1:0] ST_Q_PHASE = 2'b11;

    // Sync dibits that open the I half and the Q half of a frame
    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;

    // Number of dibits making up one sample word
    function automatic int dibit_count(input int word_w);
        return word_w / 2;
    endfunction

endpackage

// File: rtl/lvds_rx_lane.sv
// One LVDS lane: frame sync FSM, deserializer, one-word holding register
// and saturating sync-error / overflow counters.
module lvds_rx_lane
    import lvds_rx_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        dibit,
    input  logic              sync_in,
    input  logic              cnt_clear,
    input  logic              pop,
    output logic              hold_valid,
    output logic [WORD_W-1:0] hold_data,
    output logic [CNT_W-1:0]  sync_err_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [1:0]        state
);

    localparam int D     = dibit_count(WORD_W);
    localparam int HALF  = D / 2;
    localparam int IDX_W = $clog2(D);
    localparam int SH_W  = WORD_W - 2;

    logic [IDX_W-1:0] idx;
    logic [SH_W-1:0]  shreg;
    logic             sync_flag;
    logic             sync_fail;
    logic             word_done;
    logic             ovf_inc;
    logic [WORD_W-1:0] new_word;

    assign sync_fail = en && (state == ST_I_PHASE) && (idx == IDX_W'(HALF)) && (dibit != Q_SYNC);
    assign word_done = en && (state == ST_Q_PHASE) && (idx == IDX_W'(D - 1));
    assign new_word  = {shreg, dibit[1], sync_flag};
    assign ovf_inc   = word_done && hold_valid && !pop;

    // Framing FSM and shift register; disabling a lane aborts its frame silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            shreg     <= '0;
            sync_flag <= 1'b0;
        end else if (!en) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dibit == I_SYNC) begin
                        shreg     <= {shreg[SH_W-3:0], dibit};
                        sync_flag <= sync_in;
                        idx       <= IDX_W'(1);
                        state     <= ST_I_PHASE;
                    end
                end
                ST_I_PHASE: begin
                    if (idx == IDX_W'(HALF)) begin
                        if (dibit == Q_SYNC) begin
                            shreg <= {shreg[SH_W-3:0], dibit};
                            idx   <= idx + 1'b1;
                            state <= ST_Q_PHASE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        shreg <= {shreg[SH_W-3:0], dibit};
                        idx   <= idx + 1'b1;
                    end
                end
                ST_Q_PHASE: begin
                    if (idx == IDX_W'(D - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        shreg <= {shreg[SH_W-3:0], dibit};
                        idx   <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a completed word is kept unless the slot is still occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (word_done && (!hold_valid || pop)) begin
            hold_valid <= 1'b1;
            hold_data  <= new_word;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    // Saturating sync-error counter, clear wins over a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err_cnt <= '0;
        end else if (cnt_clear) begin
            sync_err_cnt <= '0;
        end else if (sync_fail && (sync_err_cnt != {CNT_W{1'b1}})) begin
            sync_err_cnt <= sync_err_cnt + 1'b1;
        end
    end

    // Saturating dropped-word counter, clear wins over a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (cnt_clear) begin
            ovf_cnt <= '0;
        end else if (ovf_inc && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lvds_rx_mc.sv
// Multi-lane LVDS receiver top: per-lane deserializers feeding a
// round-robin arbiter onto one tagged FIFO write port.
module lvds_rx_mc
    import lvds_rx_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    i_ddr_clk,
    input  logic                    i_rst,
    input  logic [2*NUM_CH-1:0]     i_ddr_data,
    input  logic [NUM_CH-1:0]       i_ch_en,
    input  logic                    i_sync_input,
    input  logic                    i_cnt_clear,
    input  logic                    i_fifo_full,
    output logic                    o_fifo_write_clk,
    output logic                    o_fifo_push,
    output logic [WORD_W-1:0]       o_fifo_data,
    output logic [1:0]              o_fifo_ch,
    output logic [NUM_CH*CNT_W-1:0] o_sync_err_cnt,
    output logic [NUM_CH*CNT_W-1:0] o_ovf_cnt,
    output logic [2*NUM_CH-1:0]     o_debug_state
);

    logic [NUM_CH-1:0]   hold_valid;
    logic [WORD_W-1:0]   hold_data [NUM_CH];
    logic [NUM_CH-1:0]   pop;
    logic [1:0]          rr_ptr;
    logic [1:0]          next_ptr;
    logic                grant_any;
    logic [1:0]          grant_idx;
    logic [WORD_W-1:0]   grant_data;
    logic [2*NUM_CH-1:0] dbl_valid;
    logic [NUM_CH-1:0]   rot_valid;
    logic [2:0]          lane_sum;

    assign o_fifo_write_clk = i_ddr_clk;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        lvds_rx_lane #(
            .WORD_W(WORD_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk         (i_ddr_clk),
            .rst         (i_rst),
            .en          (i_ch_en[c]),
            .dibit       (i_ddr_data[2*c +: 2]),
            .sync_in     (i_sync_input),
            .cnt_clear   (i_cnt_clear),
            .pop         (pop[c]),
            .hold_valid  (hold_valid[c]),
            .hold_data   (hold_data[c]),
            .sync_err_cnt(o_sync_err_cnt[c*CNT_W +: CNT_W]),
            .ovf_cnt     (o_ovf_cnt[c*CNT_W +: CNT_W]),
            .state       (o_debug_state[2*c +: 2])
        );
    end

    // Round-robin pick: rotate the valid mask so the priority lane sits at bit 0
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = 2'b00;
        grant_data = '0;
        pop        = '0;
        lane_sum   = 3'b000;
        dbl_valid  = {hold_valid, hold_valid};
        rot_valid  = NUM_CH'(dbl_valid >> rr_ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_any && rot_valid[k]) begin
                grant_any = 1'b1;
                lane_sum  = {1'b0, rr_ptr} + 3'(k);
                if (lane_sum >= 3'(NUM_CH)) begin
                    lane_sum = lane_sum - 3'(NUM_CH);
                end
                grant_idx = lane_sum[1:0];
            end
        end
        if (i_fifo_full) begin
            grant_any = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_any && (grant_idx == 2'(k))) begin
                grant_data = hold_data[k];
                pop[k]     = 1'b1;
            end
        end
        next_ptr = (grant_idx == 2'(NUM_CH - 1)) ? 2'b00 : grant_idx + 2'b01;
    end

    // Registered FIFO write port and priority pointer update
    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fifo_push <= 1'b0;
            o_fifo_data <= '0;
            o_fifo_ch   <= 2'b00;
            rr_ptr      <= 2'b00;
        end else begin
            o_fifo_push <= grant_any;
            if (grant_any) begin
                o_fifo_data <= grant_data;
                o_fifo_ch   <= grant_idx;
                rr_ptr      <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx_mc.sv
// Scoreboard bench for lvds_rx_mc: stimulus queues expected pushes,
// an independent monitor pops and compares on every FIFO write.
module tb_lvds_rx_mc;

    localparam int NUM_CH = 2;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 3;

    logic                    i_ddr_clk = 1'b0;
    logic                    i_rst = 1'b1;
    logic [2*NUM_CH-1:0]     i_ddr_data = '0;
    logic [NUM_CH-1:0]       i_ch_en = '1;
    logic                    i_sync_input = 1'b0;
    logic                    i_cnt_clear = 1'b0;
    logic                    i_fifo_full = 1'b0;
    logic                    o_fifo_write_clk;
    logic                    o_fifo_push;
    logic [WORD_W-1:0]       o_fifo_data;
    logic [1:0]              o_fifo_ch;
    logic [NUM_CH*CNT_W-1:0] o_sync_err_cnt;
    logic [NUM_CH*CNT_W-1:0] o_ovf_cnt;
    logic [2*NUM_CH-1:0]     o_debug_state;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_word;

    lvds_rx_mc #(
        .NUM_CH(NUM_CH),
        .WORD_W(WORD_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_ddr_clk       (i_ddr_clk),
        .i_rst           (i_rst),
        .i_ddr_data      (i_ddr_data),
        .i_ch_en         (i_ch_en),
        .i_sync_input    (i_sync_input),
        .i_cnt_clear     (i_cnt_clear),
        .i_fifo_full     (i_fifo_full),
        .o_fifo_write_clk(o_fifo_write_clk),
        .o_fifo_push     (o_fifo_push),
        .o_fifo_data     (o_fifo_data),
        .o_fifo_ch       (o_fifo_ch),
        .o_sync_err_cnt  (o_sync_err_cnt),
        .o_ovf_cnt       (o_ovf_cnt),
        .o_debug_state   (o_debug_state)
    );

    // Free-running DDR clock
    always #5 i_ddr_clk = ~i_ddr_clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Drive one 16-dibit frame slot on each lane (zeros where a lane is unused)
    task automatic apply_stimulus(input logic [31:0] w0, input bit v0,
                                  input logic [31:0] w1, input bit v1,
                                  input bit sync, input int ndib, input int clr_k);
        for (int k = 0; k < 16; k++) begin
            i_ddr_data[1:0] = (v0 && k < ndib) ? w0[31-2*k -: 2] : 2'b00;
            i_ddr_data[3:2] = (v1 && k < ndib) ? w1[31-2*k -: 2] : 2'b00;
            i_sync_input    = (k == 0) ? sync : 1'b0;
            i_cnt_clear     = (k == clr_k);
            @(negedge i_ddr_clk);
        end
        i_ddr_data   = '0;
        i_sync_input = 1'b0;
        i_cnt_clear  = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge i_ddr_clk);
        check_output(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every push must match the oldest expected word
    always @(negedge i_ddr_clk) begin
        if (o_fifo_push) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_push: got ch=%0d data=%h, required no push", o_fifo_ch, o_fifo_data);
            end else begin
                exp_word = exp_q.pop_front();
                check_output("push_word", 64'({o_fifo_ch, o_fifo_data}), 64'(exp_word));
            end
        end
    end

    initial begin
        repeat (3) @(negedge i_ddr_clk);
        i_rst = 1'b0;
        check_output("rst_push", 64'(o_fifo_push), 64'd0);
        check_output("rst_data", 64'(o_fifo_data), 64'd0);
        check_output("rst_ch", 64'(o_fifo_ch), 64'd0);
        check_output("rst_err", 64'(o_sync_err_cnt), 64'd0);
        check_output("rst_ovf", 64'(o_ovf_cnt), 64'd0);
        check_output("rst_dbg", 64'(o_debug_state), 64'd0);
        @(negedge i_ddr_clk);

        $display("[TB] lane 0 basic frame");
        exp_q.push_back({2'd0, 32'hA5A5_5A5B});
        apply_stimulus(32'hA5A5_5A5A, 1'b1, 32'h0, 1'b0, 1'b1, 16, -1);
        check_output("lat_early", 64'(o_fifo_push), 64'd0);
        @(negedge i_ddr_clk);
        check_output("lat_push", 64'(o_fifo_push), 64'd1);
        @(negedge i_ddr_clk);
        check_output("push_one_cycle", 64'(o_fifo_push), 64'd0);
        drain("drain_basic");

        $display("[TB] lane 1 bad Q sync then good frame");
        apply_stimulus(32'h0, 1'b0, 32'h9234_C000, 1'b1, 1'b0, 16, -1);
        check_output("sync_err_l1", 64'(o_sync_err_cnt[CNT_W +: CNT_W]), 64'd1);
        drain("drain_bad_sync");
        exp_q.push_back({2'd1, 32'h8123_4566});
        apply_stimulus(32'h0, 1'b0, 32'h8123_4567, 1'b1, 1'b0, 16, -1);
        drain("drain_good_l1");

        $display("[TB] simultaneous frames on both lanes");
        exp_q.push_back({2'd0, 32'hB00B_4001});
        exp_q.push_back({2'd1, 32'h9999_5555});
        apply_stimulus(32'hB00B_4001, 1'b1, 32'h9999_5555, 1'b1, 1'b1, 16, -1);
        drain("drain_pair1");
        exp_q.push_back({2'd0, 32'hA000_4000});
        exp_q.push_back({2'd1, 32'hAFFF_7FFE});
        apply_stimulus(32'hA000_4000, 1'b1, 32'hAFFF_7FFF, 1'b1, 1'b0, 16, -1);
        drain("drain_pair2");

        $display("[TB] backpressure with back-to-back frames");
        exp_q.push_back({2'd0, 32'h8765_4320});
        fork
            begin
                apply_stimulus(32'h8765_4321, 1'b1, 32'h0, 1'b0, 1'b0, 16, -1);
                apply_stimulus(32'h8000_4002, 1'b1, 32'h0, 1'b0, 1'b0, 16, -1);
            end
            begin
                repeat (12) @(negedge i_ddr_clk);
                i_fifo_full = 1'b1;
                repeat (20) @(negedge i_ddr_clk);
                i_fifo_full = 1'b0;
            end
        join
        check_output("ovf_l0", 64'(o_ovf_cnt[0 +: CNT_W]), 64'd1);
        drain("drain_full");

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 5; k++) begin
            i_ddr_data[1:0] = (k == 0) ? 2'b10 : 2'b11;
            @(negedge i_ddr_clk);
        end
        check_output("dbg_iphase", 64'(o_debug_state[1:0]), 64'd1);
        i_ddr_data = '0;
        i_rst = 1'b1;
        @(negedge i_ddr_clk);
        check_output("mid_rst_push", 64'(o_fifo_push), 64'd0);
        check_output("mid_rst_data", 64'(o_fifo_data), 64'd0);
        check_output("mid_rst_err", 64'(o_sync_err_cnt), 64'd0);
        check_output("mid_rst_ovf", 64'(o_ovf_cnt), 64'd0);
        check_output("mid_rst_dbg", 64'(o_debug_state), 64'd0);
        i_rst = 1'b0;
        drain("drain_after_rst");
        exp_q.push_back({2'd0, 32'h8765_4321});
        apply_stimulus(32'h8765_4321, 1'b1, 32'h0, 1'b0, 1'b1, 16, -1);
        drain("drain_post_rst");

        $display("[TB] counter saturation and clear");
        for (int n = 0; n < 9; n++) begin
            apply_stimulus(32'h0, 1'b0, 32'h8000_C000, 1'b1, 1'b0, 16, -1);
        end
        check_output("err_saturate", 64'(o_sync_err_cnt[CNT_W +: CNT_W]), 64'd7);
        apply_stimulus(32'h0, 1'b0, 32'h8000_C000, 1'b1, 1'b0, 16, 8);
        check_output("err_clear_wins", 64'(o_sync_err_cnt[CNT_W +: CNT_W]), 64'd0);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvds_rx_mc.md
# lvds_rx_mc

Multi-channel, parametrised successor of the single-lane modem LVDS deserializer. It receives NUM_CH independent 2-bit DDR lanes from the modem. Each lane is framed on I/Q sync dibits and deserialized into a WORD_W-bit sample word. The words are arbitrated round-robin onto one tagged FIFO write port, with per-channel buffering, backpressure, channel enables and saturating error/overflow counters. It sits between the LVDS input pads and the RX sample FIFO.

## Interface
Parameters:
- NUM_CH, 2: number of modem lanes, 1..4.
- WORD_W, 32: sample word width; even, multiple of 4, 16..32.
- CNT_W, 16: width of each error/overflow counter.

Ports:
- i_ddr_clk  in  1: single clock for all logic; also drives o_fifo_write_clk.
- i_rst  in  1: reset, asynchronous and active-high. One clock; all state is reset asynchronously.
- i_ddr_data  in  2*NUM_CH: lane c occupies bits [2c+1:2c].
- i_ch_en  in  NUM_CH: per-lane enable.
- i_sync_input  in  1: external time-sync marker.
- i_cnt_clear  in  1: synchronous clear of all counters.
- i_fifo_full  in  1: FIFO backpressure.
- o_fifo_write_clk  out  1: equals i_ddr_clk.
- o_fifo_push  out  1: write strobe.
- o_fifo_data  out  WORD_W: sample word.
- o_fifo_ch  out  2: channel tag of the pushed word.
- o_sync_err_cnt  out  NUM_CH*CNT_W: per-lane Q-sync failure counts.
- o_ovf_cnt  out  NUM_CH*CNT_W: per-lane dropped-word counts.
- o_debug_state  out  2*NUM_CH: per-lane FSM state.

## Operation
- Each frame is D = WORD_W/2 dibits, d0..d(D-1). d0 must be 2'b10 (I sync). d(D/2) must be 2'b01 (Q sync).
- Per-lane FSM states: IDLE=2'b00, I_PHASE=2'b01, Q_PHASE=2'b11.
- IDLE to I_PHASE when the lane is enabled and its dibit is 2'b10. At that edge, capture d0 and latch i_sync_input into the lane's sync flag. Otherwise stay in IDLE.
- I_PHASE shifts in d1..d(D/2-1). It then checks d(D/2):
  - 2'b01: shift it in and go to Q_PHASE.
  - Anything else: discard the frame, increment sync_err, go to IDLE. The next dibit is evaluated fresh in IDLE.
- Q_PHASE shifts in the remaining dibits. Final word = {d0,...,d(D-2), d(D-1)[1], sync_flag}, with d0 in the MSBs. On completion the word goes to the lane's holding register and the FSM returns to IDLE.
- Holding register, one word per lane:
  - If it is still valid when a new word completes, the new word is dropped and ovf increments. The held word is kept.
- Arbiter: round-robin over lanes with a valid holding register.
  - Grant only when i_fifo_full=0.
  - On grant: registered push of the word and its tag; that holding register is freed.
  - Priority pointer moves to granted lane + 1, modulo NUM_CH.
- i_fifo_full=1: no push. Words wait in their holding registers; nothing is dropped until a second word completes on the same lane.
- Disable: clearing i_ch_en[c] mid-frame aborts that frame silently (no counter change) and forces IDLE. A word already in the holding register still drains.
- Counters saturate at all-ones. i_cnt_clear has priority over a simultaneous increment.

## Timing
- Reset values: all FSMs IDLE, holding registers empty, o_fifo_push=0, o_fifo_data=0, o_fifo_ch=0, counters 0, RR pointer 0, o_debug_state=0.
- Latency, uncontended and not full: final dibit sampled at edge N, holding register valid after N, o_fifo_push=1 in the cycle after edge N+1.
- o_fifo_push is high exactly one cycle per word.
- Minimum frame period is D cycles (back-to-back frames, no idle gap). This exceeds NUM_CH, so with FIFO not full no overflow is possible.
- A sync error counts at the edge sampling d(D/2). An overflow counts at the edge that completes the dropped word.
- Reset asserted mid-frame: partial frames and held words are lost; no push after release until a new full frame completes.

## Structure
- Package lvds_rx_pkg holds: state encodings, I_SYNC=2'b10, Q_SYNC=2'b01, and a function deriving the dibit count from WORD_W.
- Sub-module lvds_rx_lane contains the per-lane FSM, shift register, sync flag, holding register and both counters. It is instantiated NUM_CH times via generate.
- The top level contains the round-robin arbiter, output registers and port packing.

## Test plan
- Lane 0 frame 0xA5A5_5A5A framed correctly (d0=10, d8=01), i_sync_input=1 at d0: push in the cycle after edge N+1, data = word with LSB=1, tag 0.
- Lane 1 with d8=2'b11: no push; o_sync_err_cnt lane 1 = 1. A following valid frame is accepted.
- Both lanes complete frames on the same edge, pointer 0: lane 0 pushed first, lane 1 the next cycle. The next simultaneous pair is ordered the same way (pointer wrapped back to 0).
- i_fifo_full=1 for 20 cycles while lane 0 sends two back-to-back frames: first word pushed after full deasserts, second dropped, ovf lane 0 = 1.
- i_rst pulsed at d5 of a frame: all outputs return to reset values, no push for that frame. The next clean frame pushes normally.
- Preload a counter near all-ones and force errors: it holds at all-ones. i_cnt_clear together with an error yields 0.
